// File: rtl/mem_scheduler_pkg.sv
// Types and constants shared by the memory scheduler and its arbitration logic.
package mem_scheduler_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: one-hot grant to the first pending requester after the
// previous winner, scanning circularly.
module rr_picker #(
    parameter int unsigned NUM_REQ = 3,
    localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IdxW-1:0]    i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IdxW-1:0]    o_idx
);

    logic            w_found;
    logic [IdxW-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        // Offset 1 first, so the previous winner is considered last.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            w_cand = IdxW'((32'(i_last) + i) % NUM_REQ);
            if (!w_found && i_req[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
                w_found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_scheduler.sv
// Arbitrates several requesters onto one memory bus: round-robin grant, one
// transaction at a time, with a wait timeout that completes with a fault.
module mem_scheduler
    import mem_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0][31:0] req_address_in,
    input  logic [NUM_REQ-1:0]       req_read_in,
    input  logic [NUM_REQ-1:0]       req_write_in,
    input  logic [NUM_REQ-1:0][3:0]  req_write_mask_in,
    input  logic [NUM_REQ-1:0][31:0] req_write_value_in,
    output logic [NUM_REQ-1:0][31:0] req_read_value_out,
    output logic [NUM_REQ-1:0]       req_ready_out,
    output logic [NUM_REQ-1:0]       req_fault_out,
    output logic [31:0]              address_out,
    output logic                     read_out,
    output logic                     write_out,
    output logic [3:0]               write_mask_out,
    output logic [31:0]              write_value_out,
    input  logic [31:0]              read_value_in,
    input  logic                     ready_in,
    input  logic                     fault_in,
    output logic [NUM_REQ-1:0]       grant_out
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    state_e              r_state;
    state_e              w_state_next;
    logic [NUM_REQ-1:0]  r_grant;
    logic [IdxW-1:0]     r_last;
    logic [CntW-1:0]     r_cnt;
    logic [NUM_REQ-1:0]  w_pending;
    logic [NUM_REQ-1:0]  w_pick;
    logic [IdxW-1:0]     w_pick_idx;
    logic                w_timeout;

    assign w_pending = req_read_in | req_write_in;
    assign w_timeout = (r_cnt == CntW'(TIMEOUT));

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_picker (
        .i_req   (w_pending),
        .i_last  (r_last),
        .o_grant (w_pick),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_state_next       = r_state;
        req_read_value_out = '0;
        req_ready_out      = '0;
        req_fault_out      = '0;
        address_out        = '0;
        read_out           = 1'b0;
        write_out          = 1'b0;
        write_mask_out     = '0;
        write_value_out    = '0;
        grant_out          = '0;
        case (r_state)
            StIdle: begin
                if (|w_pending) begin
                    w_state_next = StBusy;
                end
            end
            StBusy: begin
                grant_out = r_grant;
                // r_last doubles as the index of the current grant while busy.
                if (!w_pending[r_last]) begin
                    w_state_next = StIdle;
                end else begin
                    address_out     = req_address_in[r_last];
                    read_out        = req_read_in[r_last];
                    write_out       = req_write_in[r_last];
                    write_mask_out  = req_write_in[r_last] ? req_write_mask_in[r_last] : 4'b0;
                    write_value_out = req_write_value_in[r_last];
                    if (ready_in) begin
                        req_ready_out[r_last]      = 1'b1;
                        req_read_value_out[r_last] = read_value_in;
                        req_fault_out[r_last]      = fault_in;
                        w_state_next               = StIdle;
                    end else if (w_timeout) begin
                        req_ready_out[r_last] = 1'b1;
                        req_fault_out[r_last] = 1'b1;
                        w_state_next          = StIdle;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_last  <= IdxW'(NUM_REQ - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StIdle) begin
                if (|w_pending) begin
                    r_grant <= w_pick;
                    r_last  <= w_pick_idx;
                    r_cnt   <= '0;
                end
            end else if (w_state_next == StIdle) begin
                r_grant <= '0;
            end else begin
                r_cnt <= r_cnt + CntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_scheduler.sv
// Bench for mem_scheduler: randomized requesters and slave, with a queue-based
// scoreboard fed by a round-robin service-order model.
module tb_mem_scheduler;

    localparam int N   = 3;
    localparam int TMO = 255;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [3:0]  mask;
        logic [31:0] wval;
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    logic                clk;
    logic                reset;
    logic [N-1:0][31:0]  req_address_in;
    logic [N-1:0]        req_read_in;
    logic [N-1:0]        req_write_in;
    logic [N-1:0][3:0]   req_write_mask_in;
    logic [N-1:0][31:0]  req_write_value_in;
    logic [N-1:0][31:0]  req_read_value_out;
    logic [N-1:0]        req_ready_out;
    logic [N-1:0]        req_fault_out;
    logic [31:0]         address_out;
    logic                read_out;
    logic                write_out;
    logic [3:0]          write_mask_out;
    logic [31:0]         write_value_out;
    logic [31:0]         read_value_in;
    logic                ready_in;
    logic                fault_in;
    logic [N-1:0]        grant_out;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc = 0;
    int          force_lat = -1;
    bit          never_ready = 1'b0;
    int          model_last = N - 1;
    int unsigned done_cnt[N];
    int unsigned done_cyc[N];
    int unsigned issue_cyc[N];
    logic [31:0] last_rv[N];
    logic        last_fault[N];
    int          order_log[$];
    exp_t        cur[N];
    exp_t        sb[$];

    mem_scheduler dut (
        .clk                (clk),
        .reset              (reset),
        .req_address_in     (req_address_in),
        .req_read_in        (req_read_in),
        .req_write_in       (req_write_in),
        .req_write_mask_in  (req_write_mask_in),
        .req_write_value_in (req_write_value_in),
        .req_read_value_out (req_read_value_out),
        .req_ready_out      (req_ready_out),
        .req_fault_out      (req_fault_out),
        .address_out        (address_out),
        .read_out           (read_out),
        .write_out          (write_out),
        .write_mask_out     (write_mask_out),
        .write_value_out    (write_value_out),
        .read_value_in      (read_value_in),
        .ready_in           (ready_in),
        .fault_in           (fault_in),
        .grant_out          (grant_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave: answers after a random (or forced) number of wait cycles.
    initial begin
        int wcnt;
        int lat;
        wcnt = 0;
        lat  = 0;
        ready_in = 1'b0;
        fault_in = 1'b0;
        read_value_in = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                ready_in = 1'b0;
                fault_in = 1'b0;
                wcnt = 0;
            end else if (read_out || write_out) begin
                if (wcnt == 0) lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
                if (!never_ready && wcnt == lat) begin
                    ready_in      = 1'b1;
                    read_value_in = slave_data(address_out);
                    fault_in      = (address_out[3:0] == 4'hF);
                end else begin
                    ready_in      = 1'b0;
                    read_value_in = $urandom;
                    fault_in      = 1'($urandom_range(0, 1));
                end
                wcnt++;
            end else begin
                ready_in = 1'b0;
                fault_in = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever any requester sees ready.
    initial begin
        int ai;
        exp_t e;
        logic [N-1:0][31:0] ev;
        logic [N-1:0] eh;
        forever begin
            @(negedge clk);
            #1;
            check("ready_onehot", $countones(req_ready_out) <= 1, 1);
            check("fault_without_ready", req_fault_out & ~req_ready_out, 0);
            if (req_ready_out != '0) begin
                ai = 0;
                for (int i = 0; i < N; i++) if (req_ready_out[i]) ai = i;
                done_cnt[ai]++;
                done_cyc[ai]   = cyc;
                last_rv[ai]    = req_read_value_out[ai];
                last_fault[ai] = req_fault_out[ai];
                order_log.push_back(ai);
                if (sb.size() == 0) begin
                    check("unexpected_ready", req_ready_out, 0);
                end else begin
                    e  = sb.pop_front();
                    eh = '0;
                    eh[e.idx] = 1'b1;
                    ev = '0;
                    ev[e.idx] = e.rdata;
                    check("ready_vec", req_ready_out, eh);
                    check("fault_vec", req_fault_out, e.fault ? eh : '0);
                    check("read_value_vec", req_read_value_out, ev);
                    check("grant_vec", grant_out, eh);
                    check("bus_fields",
                          {address_out, read_out, write_out, write_mask_out, write_value_out},
                          {e.addr, e.rd, e.wr, (e.wr ? e.mask : 4'b0), e.wval});
                end
            end
        end
    end

    task automatic drive_req(input int j, input bit rd, input bit wr, input logic [31:0] a,
                             input logic [3:0] m, input logic [31:0] v, input bit tmo);
        req_address_in[j]     = a;
        req_read_in[j]        = rd;
        req_write_in[j]       = wr;
        req_write_mask_in[j]  = m;
        req_write_value_in[j] = v;
        cur[j].idx   = j;
        cur[j].addr  = a;
        cur[j].rd    = rd;
        cur[j].wr    = wr;
        cur[j].mask  = m;
        cur[j].wval  = v;
        cur[j].rdata = tmo ? 32'h0 : slave_data(a);
        cur[j].fault = tmo ? 1'b1 : (a[3:0] == 4'hF);
        issue_cyc[j] = cyc;
    endtask

    task automatic drive_rand(input int j);
        bit op;
        op = 1'($urandom_range(0, 1));
        drive_req(j, !op, op, $urandom, 4'($urandom_range(0, 15)), $urandom, 1'b0);
    endtask

    // Expected service order: circular scan from the requester after the last
    // one served; then hold each request until it sees ready.
    task automatic serve(input logic [N-1:0] pend);
        int unsigned base[N];
        logic [N-1:0] left;
        int j;
        int last;
        left = pend;
        last = model_last;
        for (int k = 1; k <= N; k++) begin
            j = (model_last + k) % N;
            if (pend[j]) begin
                sb.push_back(cur[j]);
                last = j;
            end
        end
        model_last = last;
        for (int i = 0; i < N; i++) base[i] = done_cnt[i];
        for (int c = 0; c < 1000 && left != '0; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (left[i] && done_cnt[i] != base[i]) begin
                    req_read_in[i]  = 1'b0;
                    req_write_in[i] = 1'b0;
                    left[i] = 1'b0;
                end
            end
        end
        if (left != '0) begin
            check("serve_budget_left", left, 0);
            req_read_in  = '0;
            req_write_in = '0;
            sb.delete();
        end
    endtask

    initial begin
        logic [N-1:0] pend;
        reset              = 1'b0;
        req_address_in     = '0;
        req_read_in        = '0;
        req_write_in       = '0;
        req_write_mask_in  = '0;
        req_write_value_in = '0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_req_outputs", {req_read_value_out, req_ready_out, req_fault_out}, 0);
        check("reset_bus_outputs", {address_out, read_out, write_out, write_mask_out,
                                    write_value_out, grant_out}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // All three requesting: 0,1,2,0,1,2 with one idle bubble between grants.
        force_lat = 0;
        order_log.delete();
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < N; j++) drive_rand(j);
            serve(3'b111);
            check("bubble_0_to_1", done_cyc[1] - done_cyc[0], 2);
            check("bubble_1_to_2", done_cyc[2] - done_cyc[1], 2);
        end
        check("rr_order_len", order_log.size(), 6);
        if (order_log.size() == 6)
            for (int i = 0; i < 6; i++) check("rr_order", order_log[i], i % 3);

        // Single read, zero-wait slave.
        drive_req(0, 1'b1, 1'b0, 32'h4110_DEAD, 4'h0, 32'h0, 1'b0);
        serve(3'b001);
        check("single_read_latency", done_cyc[0] - issue_cyc[0] + 1, 2);
        check("single_read_value", last_rv[0], 32'hDEADBEEF);
        check("single_read_fault", last_fault[0], 0);

        // Masked write on requester 1.
        force_lat = 2;
        drive_req(1, 1'b0, 1'b1, 32'hA000_0040, 4'b0011, 32'h1234_5678, 1'b0);
        serve(3'b010);
        force_lat = -1;

        // Slave never answers: timeout completion with fault.
        never_ready = 1'b1;
        drive_req(2, 1'b1, 1'b0, 32'h0000_0100, 4'h0, 32'h0, 1'b1);
        serve(3'b100);
        check("timeout_latency", done_cyc[2] - issue_cyc[2], TMO + 1);
        check("timeout_fault", last_fault[2], 1);
        check("timeout_value", last_rv[2], 0);
        check("idle_after_timeout", {grant_out, read_out, write_out}, 0);
        never_ready = 1'b0;

        // Ready arrives on the timeout cycle itself: normal completion wins.
        force_lat = TMO;
        drive_req(0, 1'b1, 1'b0, 32'h0000_2220, 4'h0, 32'h0, 1'b0);
        serve(3'b001);
        check("coincident_latency", done_cyc[0] - issue_cyc[0], TMO + 1);
        check("coincident_fault", last_fault[0], 0);
        force_lat = -1;

        // Granted requester withdraws mid-transaction.
        never_ready = 1'b1;
        drive_req(1, 1'b1, 1'b0, 32'h0000_3330, 4'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check("abort_grant_busy", grant_out, 3'b010);
        req_read_in[1] = 1'b0;
        #1;
        check("abort_bus_zero", {address_out, read_out, write_out, write_mask_out,
                                 write_value_out}, 0);
        check("abort_no_ready", {req_ready_out, req_fault_out}, 0);
        @(posedge clk);
        #1;
        check("abort_back_idle", grant_out, 0);
        model_last = 1;

        // Reset in the middle of a transaction.
        drive_req(2, 1'b0, 1'b1, 32'h0000_4440, 4'hF, 32'hCAFE_F00D, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_grant", grant_out, 3'b100);
        reset = 1'b0;
        #1;
        check("midreset_req_outputs", {req_read_value_out, req_ready_out, req_fault_out}, 0);
        check("midreset_bus_outputs", {address_out, read_out, write_out, write_mask_out,
                                       write_value_out, grant_out}, 0);
        req_read_in  = '0;
        req_write_in = '0;
        @(negedge clk);
        reset = 1'b1;
        never_ready = 1'b0;
        model_last = N - 1;
        @(posedge clk);
        #1;
        order_log.delete();
        for (int j = 0; j < N; j++) drive_rand(j);
        serve(3'b111);
        check("first_after_reset", (order_log.size() > 0) ? order_log[0] : -1, 0);

        // Random subsets of requesters with random slave latency.
        repeat (40) begin
            pend = N'($urandom_range(1, (1 << N) - 1));
            for (int j = 0; j < N; j++) if (pend[j]) drive_rand(j);
            serve(pend);
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
